gate_tester: RTL and testbench
==============================

Name: gate_tester

Overview:
- Stimulus driver and checker for any 2-input combinational gate in the lab designs. It acts as the other end of the gate's A/B/out interface.
- On `start`, it drives all four {A,B} input vectors in order. It waits a settle interval for each vector, then samples the gate output.
- At the end it compares the captured truth table against a parameterised expected table and reports pass/fail plus a mismatch count.
- Sits between board inputs (start button, already debounced) and a device-under-test gate instance; results go to LEDs.

Parameters:
- EXPECT, 4'b1000, expected truth table; bit i is the expected output for vector i, where {A,B} = i. Default is AND.
- SETTLE, 3, extra hold cycles per vector before sampling; legal range 0..15.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  start a test run; sampled only in IDLE.
- A  output  1  gate input A stimulus.
- B  output  1  gate input B stimulus.
- gate_out  input  1  output of the gate under test.
- busy  output  1  high while a run is in progress (DRIVE state).
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  1 if captured == EXPECT for the last completed run.
- captured  output  4  truth table captured in the last run; bit i holds the sample for vector i.
- err_cnt  output  3  number of mismatching bits in the last run, 0..4.

Behaviour:
- Reset and clocking:
  - One clock. Reset is synchronous and active-low: `rst_n` is sampled on the rising edge of `clk`.
  - Reset values: A=0, B=0, busy=0, done=0, pass=0, captured=4'b0000, err_cnt=0, state=IDLE, idx=0, cnt=0.
- States:
  - IDLE: A=B=0, busy=0. When start=1 at an edge, go to DRIVE with idx=0, cnt=0.
  - DRIVE: A=idx[1], B=idx[0] (registered), busy=1.
    - Each edge with cnt<SETTLE: cnt++.
    - Edge with cnt==SETTLE: captured[idx] <= gate_out.
    - At that edge, if idx<3: idx++, cnt=0, stay in DRIVE. If idx==3: go to DONE.
  - DONE: lasts one cycle. done=1, busy=0, A=B=0. Next state is IDLE unconditionally.
- Vector timing: each vector is held for exactly SETTLE+1 cycles. gate_out is sampled at the final edge of that window.
- Pass and err_cnt:
  - Both are registered on the edge entering DONE.
  - They are computed from the final captured value, i.e. {gate_out, captured[2:0]}.
  - err_cnt = popcount(final captured XOR EXPECT); pass = (err_cnt==0).
  - pass, err_cnt and captured are valid in the DONE cycle and hold until the next run starts.
- Start of a new run: on the edge leaving IDLE with start=1, clear pass=0, err_cnt=0, captured=0.
- Latency: with start sampled at edge 0, done is high in cycle 4*(SETTLE+1)+1. This is cycle 17 for SETTLE=3 and cycle 5 for SETTLE=0.
- start is ignored in DRIVE and DONE; no queuing.
- A start held high re-triggers only after passing through IDLE. Earliest restart is the cycle after DONE.
- Reset mid-run: abandon the run on that edge. All outputs return to their reset values; partial results are discarded.
- err_cnt width: 3 bits, covering the maximum value of 4.

Decomposition:
- Shared package `gate_test_pkg`:
  - State enum: IDLE, DRIVE, DONE.
  - NUM_VEC = 4.
  - Truth-table constants: TT_AND=4'b1000, TT_OR=4'b1110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001.
- Sub-module `settle_timer`: loadable down/up counter with a `tick` at SETTLE. It is optional but natural, and is reused by other lab stimulus blocks.

Test Plan:
- DUT = ideal AND, EXPECT=TT_AND, SETTLE=3, pulse start -> A/B sequence 00,01,10,11 for 4 cycles each; done in cycle 17; captured=1000, pass=1, err_cnt=0.
- DUT = NOR (A ~| B), EXPECT=TT_AND -> captured=0001, pass=0, err_cnt=2.
- gate_out tied to 1, EXPECT=TT_AND -> captured=1111, err_cnt=3, pass=0; then tied to 0 -> captured=0000, err_cnt=1.
- SETTLE=0, ideal XOR, EXPECT=TT_XOR -> one cycle per vector; done in cycle 5; pass=1.
- start re-pulsed during DRIVE at cycle 6 -> no restart; done still in cycle 17; exactly one done pulse.
- rst_n=0 at cycle 9 of a run -> next edge: A=B=0, busy=0, captured=0, pass=0; a new start runs a full clean sequence from vector 00.

Source files
------------

// File: rtl/gate_test_pkg.sv
// Shared types and constants for the lab gate stimulus/checker blocks.
package gate_test_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;

  localparam int NUM_VEC = 4;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/settle_timer.sv
// Up counter that clears on load and flags tick once it reaches SETTLE.
module settle_timer #(
  parameter int SETTLE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic tick_o
);
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)    cnt_d = 4'd0;
    else if (en_i) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == 4'(SETTLE));
endmodule

// File: rtl/gate_tester.sv
// Drives all four {A,B} vectors into a 2-input gate, captures its truth
// table and checks it against EXPECT.
module gate_tester
  import gate_test_pkg::*;
#(
  parameter logic [3:0] EXPECT = TT_AND,
  parameter int         SETTLE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       gate_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] captured,
  output logic [2:0] err_cnt
);
  state_e     st_q, st_d;
  logic [1:0] idx_q, idx_d;
  logic       a_q, a_d, b_q, b_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0] cap_q, cap_d;
  logic [2:0] err_q, err_d;
  logic       tick, in_drive;

  assign in_drive = (st_q == DRIVE);

  // Timer restarts for every vector and is held clear outside DRIVE.
  settle_timer #(.SETTLE(SETTLE)) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (!in_drive || tick),
    .en_i   (in_drive),
    .tick_o (tick)
  );

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    a_d    = a_q;
    b_d    = b_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;
    cap_d  = cap_q;
    err_d  = err_q;
    case (st_q)
      IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          st_d   = DRIVE;
          idx_d  = 2'd0;
          busy_d = 1'b1;
          pass_d = 1'b0;
          err_d  = 3'd0;
          cap_d  = 4'd0;
        end
      end
      DRIVE: begin
        if (tick) begin
          cap_d[idx_q] = gate_out;
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
            a_d   = idx_d[1];
            b_d   = idx_d[0];
          end else begin
            st_d   = DONE;
            a_d    = 1'b0;
            b_d    = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
            err_d  = popcount4(cap_d ^ EXPECT);
            pass_d = (cap_d == EXPECT);
          end
        end
      end
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      idx_q  <= 2'd0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      cap_q  <= 4'd0;
      err_q  <= 3'd0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      a_q    <= a_d;
      b_q    <= b_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      cap_q  <= cap_d;
      err_q  <= err_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign captured = cap_q;
  assign err_cnt  = err_q;
endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: two instances (SETTLE=3/AND and SETTLE=0/XOR)
// driving modelled gates, checked cycle by cycle against a timeline model.
module tb_gate_tester;
  import gate_test_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic a0, b0, g0, busy0, done0, pass0;
  logic a1, b1, g1, busy1, done1, pass1;
  logic [3:0] cap0, cap1;
  logic [2:0] err0, err1;
  int mode0 = 0;  // 0 AND, 1 NOR, 2 tied 1, 3 tied 0, 4 XOR

  int total = 0, passed = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  function automatic logic gate(input int m, input logic a, input logic b);
    case (m)
      0: gate = a & b;
      1: gate = ~(a | b);
      2: gate = 1'b1;
      3: gate = 1'b0;
      default: gate = a ^ b;
    endcase
  endfunction

  assign g0 = gate(mode0, a0, b0);
  assign g1 = gate(4, a1, b1);

  gate_tester #(.EXPECT(TT_AND), .SETTLE(3)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .A(a0), .B(b0), .gate_out(g0),
    .busy(busy0), .done(done0), .pass(pass0), .captured(cap0), .err_cnt(err0));

  gate_tester #(.EXPECT(TT_XOR), .SETTLE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .gate_out(g1),
    .busy(busy1), .done(done1), .pass(pass1), .captured(cap1), .err_cnt(err1));

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: a run is a timeline of edges e counted from the start edge.
  int         ms[2] = '{3, 0};
  logic [3:0] mexp[2] = '{4'b1000, 4'b0110};
  bit         mrun[2], mdone[2], mpass[2];
  int         me[2], merr[2];
  logic [3:0] mcap[2];

  task automatic mstep(input int d, input logic st, input int m);
    int w, v;
    w = ms[d] + 1;
    if (!rst_n) begin
      mrun[d] = 0; mdone[d] = 0; mpass[d] = 0; merr[d] = 0; mcap[d] = '0;
    end else if (mrun[d]) begin
      me[d]++;
      if (me[d] % w == 0) begin
        v = me[d] / w - 1;
        mcap[d][v] = gate(m, v[1], v[0]);
      end
      if (me[d] == 4 * w) begin
        mrun[d] = 0; mdone[d] = 1; merr[d] = 0;
        for (int i = 0; i < 4; i++) if (mcap[d][i] != mexp[d][i]) merr[d]++;
        mpass[d] = (merr[d] == 0);
      end
    end else if (mdone[d]) begin
      mdone[d] = 0;
    end else if (st) begin
      mrun[d] = 1; me[d] = 0; mcap[d] = '0; mpass[d] = 0; merr[d] = 0;
    end
  endtask

  function automatic logic [11:0] mout(input int d);
    int v;
    logic a, b;
    v = mrun[d] ? me[d] / (ms[d] + 1) : 0;
    a = mrun[d] ? v[1] : 1'b0;
    b = mrun[d] ? v[0] : 1'b0;
    mout = {a, b, mrun[d], mdone[d], mpass[d], mcap[d], 3'(merr[d])};
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rst_n) chk_en = 1;
    mstep(0, start0, mode0);
    mstep(1, start1, 4);
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("u0_cycle", {a0, b0, busy0, done0, pass0, cap0, err0}, mout(0));
      chk("u1_cycle", {a1, b1, busy1, done1, pass1, cap1, err1}, mout(1));
    end
  end

  function automatic logic dn(input int d);
    dn = (d == 0) ? done0 : done1;
  endfunction

  task automatic do_run(input int d, output int n);
    @(negedge clk);
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    n = 0;
    while (!dn(d) && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run0(input int m, input string nm, input logic [3:0] ecap,
                      input logic ep, input logic [2:0] ee);
    int n;
    mode0 = m;
    do_run(0, n);
    chk({nm, "_lat"}, 12'(n), 12'd16);
    chk({nm, "_res"}, {4'd0, cap0, pass0, err0}, {4'd0, ecap, ep, ee});
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n, first, pulses;
    repeat (3) @(negedge clk);
    chk("reset_state", {a0, b0, busy0, done0, pass0, cap0, err0}, 12'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run0(0, "and",   4'b1000, 1'b1, 3'd0);
    run0(1, "nor",   4'b0001, 1'b0, 3'd2);
    run0(2, "tie1",  4'b1111, 1'b0, 3'd3);
    run0(3, "tie0",  4'b0000, 1'b0, 3'd1);

    do_run(1, n);
    chk("xor_s0_lat", 12'(n), 12'd4);
    chk("xor_s0_res", {4'd0, cap1, pass1, err1}, {4'd0, 4'b0110, 1'b1, 3'd0});
    repeat (2) @(negedge clk);

    // start re-pulsed mid-run must not restart it
    mode0 = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    n = 0; first = -1; pulses = 0;
    for (int k = 0; k < 30; k++) begin
      if (done0) begin pulses++; if (first < 0) first = n; end
      start0 = (n == 6);
      @(negedge clk);
      n++;
    end
    start0 = 1'b0;
    chk("repulse_lat", 12'(first), 12'd16);
    chk("repulse_cnt", 12'(pulses), 12'd1);

    // start held high on the fast instance re-triggers after each DONE
    start1 = 1'b1;
    repeat (15) @(negedge clk);
    start1 = 1'b0;
    repeat (8) @(negedge clk);

    // reset in the middle of a run
    mode0 = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrun_busy", {11'd0, busy0}, 12'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_rst", {a0, b0, busy0, done0, pass0, cap0, err0}, 12'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run0(0, "after_rst", 4'b1000, 1'b1, 3'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
